div_wb_merge: RTL and testbench
===============================

# div_wb_merge

Write-back merge and hazard unit for the pipelined divider. It accepts results leaving the divider pipeline, which cannot be stalled and arrive on fixed-latency pipeline registers with `rd_addr == 0` meaning no result. It merges them with the main MEM/WB write stream onto the single register-file write port and buffers divider results in a small FIFO whenever the port is busy. It raises the ID-stage stall for RAW/WAW hazards against in-flight and buffered divider results.

## Interface
- `DEPTH`, default `` `DIV_WB_FIFO_DEPTH `` (4): divider-result buffer entries; power of two, ≥2.
- `clk` in 1: clock.
- `rst` in 1: reset. One clock; reset is asynchronous and active-high.
- `div_rd_addr` in 5: divider result destination; 0 means no result this cycle.
- `div_rd_data` in 32: divider result, valid when `div_rd_addr != 0`.
- `div_rd_addr_flags` in 32: one-hot OR of destinations in flight inside the divider, including the stage being issued.
- `wb_we_i` in 1: main pipeline write enable.
- `wb_rd_addr_i` in 5: main pipeline destination.
- `wb_rd_data_i` in 32: main pipeline data.
- `id_rs1_addr`, `id_rs2_addr` in 5 each: ID-stage source registers.
- `id_rs1_used`, `id_rs2_used` in 1 each: the source is actually read.
- `id_rd_addr` in 5: ID-stage destination.
- `id_rd_we` in 1: the ID instruction writes `id_rd_addr`.
- `rf_we` out 1: register-file write enable.
- `rf_waddr` out 5: register-file write address.
- `rf_wdata` out 32: register-file write data.
- `stall_o` out 1: hold IF/ID and inject a bubble into EX.
- `fifo_count` out `$clog2(DEPTH)+1`: entries buffered.
- `ovf_o` out 1: sticky overflow error.

## Operation
- Main write is active when `wb_we_i && wb_rd_addr_i != 0`. Divider arrival is active when `div_rd_addr != 0`.
- Write-port priority, evaluated combinationally each cycle:
  1. Main write active: write the main data.
  2. Otherwise, FIFO non-empty: write the FIFO head and pop it.
  3. Otherwise, divider arrival active: write the divider result directly.
  4. Otherwise: `rf_we = 0`.
- Push rule: a divider arrival is pushed at the tail unless it took path 3. A push and a pop in the same cycle are legal; count is unchanged.
- Ordering: FIFO order equals divider completion order. Divider results are never reordered among themselves.
- `pending_mask` is the OR of one-hot(addr) over valid FIFO entries. Bit 0 is always masked.
- `busy_mask = (div_rd_addr_flags | pending_mask) & ~32'h1`.
- `stall_o` is asserted when any of the following holds:
  - `id_rs1_used && busy_mask[id_rs1_addr]`
  - `id_rs2_used && busy_mask[id_rs2_addr]`
  - `id_rd_we && busy_mask[id_rd_addr]` (WAW: a later main write must not be overwritten by an older divider drain)
  - `fifo_count >= DEPTH-1` (almost full: stops new divider issue)
- Overflow: an arrival that must be pushed while `fifo_count == DEPTH` is dropped, and `ovf_o` is set. `ovf_o` is cleared only by `rst`.
- A simultaneous main write and divider arrival to the same nonzero register are not prevented here. The main write goes first and the divider result is buffered and written later. The WAW stall keeps correct software from reaching this case.

## Timing
- Write port is combinational from inputs and FIFO head: zero-cycle latency for path 3.
- A buffered result is written on the first cycle with no main write and no older entry ahead of it.
- `fifo_count`, `ovf_o` and the pointers are registered; they update on the `clk` rising edge.
- `stall_o` is combinational and reflects the registered FIFO state plus the current inputs.
- Reset (async, mid-operation included): pointers, count and `ovf_o` go to 0 and buffered results are discarded.
- While `rst` is high, `rf_we = 0` and `stall_o = 0`. `rf_waddr` and `rf_wdata` are 0.
- Pointers wrap modulo DEPTH.
- Full is `count == DEPTH` and empty is `count == 0`. Count is never derived from pointer equality alone.

## Structure
- `defines.vh` holds `` `DIV_WB_FIFO_DEPTH ``. The x0 address constant is the existing one.
- One sub-module, `div_wb_fifo`: a synchronous FIFO.
  - Ports: push/pop/data, `count`, `empty`, `full`.
  - Output: per-entry address one-hot OR (`pending_mask`).
  - Reset: async.
- Priority mux, stall logic and overflow flag stay in `div_wb_merge`.

## Test plan
- Idle port: divider delivers `x5=0x0000_0007` with `wb_we_i=0` → same cycle `rf_we=1`, `rf_waddr=5`, `rf_wdata=7`; `fifo_count` stays 0.
- Conflict: main writes `x3=0xAA` while divider delivers `x6=0x11`.
  - That cycle: port writes x3, `fifo_count=1`, `stall_o=1` for `id_rs1_addr=6, used`.
  - Next cycle with `wb_we_i=0`: port writes `x6=0x11`, count 0, stall drops.
- Back-to-back: 4 consecutive divider results (x1..x4) during 4 main writes.
  - Count reaches 3 → `stall_o=1` from almost-full.
  - Drains x1..x4 in order once main goes idle.
  - Push and pop in the same cycle keep the count constant.
- Overflow: force 5 buffered arrivals with DEPTH=4 and continuous main writes → fifth dropped, `ovf_o=1`, held until `rst`.
- Hazards:
  - `div_rd_addr_flags` bit 9 set with `id_rs2_addr=9, used` → `stall_o=1`.
  - Same with `id_rs2_used=0` → 0.
  - `id_rd_addr=9, id_rd_we=1` → 1.
  - Address 0 → never stalls.
- Async reset asserted mid-cycle with 2 buffered entries → count, `ovf_o` and `rf_we` go to 0 immediately; no stale write after release.

Source files
------------

// File: rtl/div_wb_merge_pkg.sv
// Shared types and helpers for the divider write-back merge unit.
// Holds the x0 address constant, the buffered-entry layout and the one-hot decode.
package div_wb_merge_pkg;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_entry_t;

    // Which source drives the register-file write port this cycle.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_MAIN = 2'd1,
        SRC_FIFO = 2'd2,
        SRC_DIV  = 2'd3
    } wb_src_e;

    function automatic logic [31:0] reg_onehot(input logic [4:0] addr);
        reg_onehot = 32'h1 << addr;
    endfunction

endpackage

// File: rtl/div_wb_fifo.sv
// Small FIFO buffering divider results until the register-file port is free.
// Also publishes the OR of one-hot destinations of every valid entry.
module div_wb_fifo
    import div_wb_merge_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH) + 1,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  wb_entry_t       push_entry,
    input  logic            pop,
    output wb_entry_t       head,
    output logic [CW-1:0]   count,
    output logic            empty,
    output logic            full,
    output logic [31:0]     pending_mask
);

    wb_entry_t        mem [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            valid  <= '0;
        end else begin
            if (do_pop) begin
                rd_ptr        <= rd_ptr + 1'b1;
                valid[rd_ptr] <= 1'b0;
            end
            if (do_push) begin
                wr_ptr        <= wr_ptr + 1'b1;
                valid[wr_ptr] <= 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i]) begin
                pending_mask = pending_mask | reg_onehot(mem[i].addr);
            end
        end
        pending_mask[0] = 1'b0;
    end

endmodule

// File: rtl/div_wb_merge.sv
// Merges non-stallable divider results with the main MEM/WB stream onto one
// register-file write port and raises the ID stall for divider RAW/WAW hazards.
`ifndef DIV_WB_FIFO_DEPTH
`define DIV_WB_FIFO_DEPTH 4
`endif

module div_wb_merge
    import div_wb_merge_pkg::*;
#(
    parameter int DEPTH = `DIV_WB_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4:0]             div_rd_addr,
    input  logic [31:0]            div_rd_data,
    input  logic [31:0]            div_rd_addr_flags,
    input  logic                   wb_we_i,
    input  logic [4:0]             wb_rd_addr_i,
    input  logic [31:0]            wb_rd_data_i,
    input  logic [4:0]             id_rs1_addr,
    input  logic [4:0]             id_rs2_addr,
    input  logic                   id_rs1_used,
    input  logic                   id_rs2_used,
    input  logic [4:0]             id_rd_addr,
    input  logic                   id_rd_we,
    output logic                   rf_we,
    output logic [4:0]             rf_waddr,
    output logic [31:0]            rf_wdata,
    output logic                   stall_o,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   ovf_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic      main_act;
    logic      div_act;
    logic      need_push;
    logic      fifo_pop;
    logic      fifo_empty;
    logic      fifo_full;
    wb_entry_t fifo_head;
    wb_entry_t div_entry;
    wb_src_e   src;
    logic [31:0] pending_mask;
    logic [31:0] busy_mask;

    assign main_act  = wb_we_i && (wb_rd_addr_i != REG_X0);
    assign div_act   = (div_rd_addr != REG_X0);
    assign div_entry = '{addr: div_rd_addr, data: div_rd_data};

    always_comb begin
        src = SRC_NONE;
        if (rst) begin
            src = SRC_NONE;
        end else if (main_act) begin
            src = SRC_MAIN;
        end else if (!fifo_empty) begin
            src = SRC_FIFO;
        end else if (div_act) begin
            src = SRC_DIV;
        end
    end

    // Any divider arrival that was not written straight through must be buffered.
    assign need_push = !rst && div_act && (src != SRC_DIV);
    assign fifo_pop  = (src == SRC_FIFO);

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = REG_X0;
        rf_wdata = '0;
        case (src)
            SRC_MAIN: begin
                rf_we    = 1'b1;
                rf_waddr = wb_rd_addr_i;
                rf_wdata = wb_rd_data_i;
            end
            SRC_FIFO: begin
                rf_we    = 1'b1;
                rf_waddr = fifo_head.addr;
                rf_wdata = fifo_head.data;
            end
            SRC_DIV: begin
                rf_we    = 1'b1;
                rf_waddr = div_rd_addr;
                rf_wdata = div_rd_data;
            end
            default: begin
                rf_we    = 1'b0;
                rf_waddr = REG_X0;
                rf_wdata = '0;
            end
        endcase
    end

    div_wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push         (need_push),
        .push_entry   (div_entry),
        .pop          (fifo_pop),
        .head         (fifo_head),
        .count        (fifo_count),
        .empty        (fifo_empty),
        .full         (fifo_full),
        .pending_mask (pending_mask)
    );

    assign busy_mask = (div_rd_addr_flags | pending_mask) & ~32'h1;

    // Almost-full term keeps the divider from issuing into a buffer it cannot drain.
    always_comb begin
        stall_o = 1'b0;
        if (!rst) begin
            stall_o = (id_rs1_used && busy_mask[id_rs1_addr])
                   || (id_rs2_used && busy_mask[id_rs2_addr])
                   || (id_rd_we    && busy_mask[id_rd_addr])
                   || (fifo_count >= CW'(DEPTH - 1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_o <= 1'b0;
        end else if (need_push && fifo_full) begin
            ovf_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_div_wb_merge.sv
// Directed bench for div_wb_merge: write-port priority, buffering order,
// overflow, hazard stalls and asynchronous reset.
module tb_div_wb_merge;

    logic        clk;
    logic        rst;
    logic [4:0]  div_rd_addr;
    logic [31:0] div_rd_data;
    logic [31:0] div_rd_addr_flags;
    logic        wb_we_i;
    logic [4:0]  wb_rd_addr_i;
    logic [31:0] wb_rd_data_i;
    logic [4:0]  id_rs1_addr;
    logic [4:0]  id_rs2_addr;
    logic        id_rs1_used;
    logic        id_rs2_used;
    logic [4:0]  id_rd_addr;
    logic        id_rd_we;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        stall_o;
    logic [2:0]  fifo_count;
    logic        ovf_o;

    int errors = 0;
    int checks = 0;

    div_wb_merge #(.DEPTH(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .div_rd_addr       (div_rd_addr),
        .div_rd_data       (div_rd_data),
        .div_rd_addr_flags (div_rd_addr_flags),
        .wb_we_i           (wb_we_i),
        .wb_rd_addr_i      (wb_rd_addr_i),
        .wb_rd_data_i      (wb_rd_data_i),
        .id_rs1_addr       (id_rs1_addr),
        .id_rs2_addr       (id_rs2_addr),
        .id_rs1_used       (id_rs1_used),
        .id_rs2_used       (id_rs2_used),
        .id_rd_addr        (id_rd_addr),
        .id_rd_we          (id_rd_we),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .stall_o           (stall_o),
        .fifo_count        (fifo_count),
        .ovf_o             (ovf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] da, input logic [31:0] dd);
        wb_we_i      = we;
        wb_rd_addr_i = wa;
        wb_rd_data_i = wd;
        div_rd_addr  = da;
        div_rd_data  = dd;
        #1;
    endtask

    task automatic check_port(input string tag, input logic we, input logic [4:0] wa,
                              input logic [31:0] wd);
        check({tag, ".we"}, 32'(rf_we), 32'(we));
        if (we) begin
            check({tag, ".addr"}, 32'(rf_waddr), 32'(wa));
            check({tag, ".data"}, rf_wdata, wd);
        end
    endtask

    task automatic set_id(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                          input logic u2, input logic [4:0] rd, input logic we);
        id_rs1_addr = rs1;
        id_rs1_used = u1;
        id_rs2_addr = rs2;
        id_rs2_used = u2;
        id_rd_addr  = rd;
        id_rd_we    = we;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        div_rd_addr_flags = 32'h0000_0200;
        set_id(5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        drive(1'b1, 5'd3, 32'h55, 5'd4, 32'h66);
        check("rst.rf_we", 32'(rf_we), 0);
        check("rst.waddr", 32'(rf_waddr), 0);
        check("rst.wdata", rf_wdata, 0);
        check("rst.stall", 32'(stall_o), 0);
        check("rst.count", 32'(fifo_count), 0);
        check("rst.ovf", 32'(ovf_o), 0);
        tick();
        rst = 1'b0;
        div_rd_addr_flags = '0;
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);

        // Idle port: divider result goes straight through.
        drive(1'b0, 5'd0, 0, 5'd5, 32'h0000_0007);
        check_port("idle", 1'b1, 5'd5, 32'h7);
        tick();
        check("idle.count", 32'(fifo_count), 0);

        // Conflict: main wins, divider result is buffered.
        set_id(5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        drive(1'b1, 5'd3, 32'hAA, 5'd6, 32'h11);
        check_port("conf.main", 1'b1, 5'd3, 32'hAA);
        tick();
        check("conf.count1", 32'(fifo_count), 1);
        check("conf.stall1", 32'(stall_o), 1);
        drive(1'b0, 5'd0, 0, 5'd0, 0);
        check_port("conf.drain", 1'b1, 5'd6, 32'h11);
        tick();
        check("conf.count0", 32'(fifo_count), 0);
        check("conf.stall0", 32'(stall_o), 0);
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);

        // Back-to-back: four buffered results, almost-full stall, ordered drain.
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 5'(9 + i), 32'h1000 + 32'(i), 5'(i), 32'h100 + 32'(i));
            check_port($sformatf("b2b.main%0d", i), 1'b1, 5'(9 + i), 32'h1000 + 32'(i));
            tick();
            check($sformatf("b2b.count%0d", i), 32'(fifo_count), 32'(i));
            check($sformatf("b2b.stall%0d", i), 32'(stall_o), (i >= 3) ? 1 : 0);
        end
        drive(1'b0, 5'd0, 0, 5'd0, 0);
        check_port("b2b.d1", 1'b1, 5'd1, 32'h101);
        tick();
        check("b2b.dc1", 32'(fifo_count), 3);
        drive(1'b0, 5'd0, 0, 5'd7, 32'h77);
        check_port("b2b.d2", 1'b1, 5'd2, 32'h102);
        tick();
        check("b2b.pushpop", 32'(fifo_count), 3);
        drive(1'b0, 5'd0, 0, 5'd0, 0);
        check_port("b2b.d3", 1'b1, 5'd3, 32'h103);
        tick();
        check_port("b2b.d4", 1'b1, 5'd4, 32'h104);
        tick();
        check_port("b2b.d7", 1'b1, 5'd7, 32'h77);
        tick();
        check("b2b.empty", 32'(fifo_count), 0);
        check_port("b2b.idle", 1'b0, 5'd0, 0);
        check("b2b.ovf", 32'(ovf_o), 0);

        // Overflow: fifth arrival under continuous main writes is dropped.
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 5'd30, 32'hF0 + 32'(i), 5'(20 + i), 32'h200 + 32'(i));
            tick();
            check($sformatf("ovf.count%0d", i), 32'(fifo_count), (i >= 4) ? 4 : 32'(i));
            check($sformatf("ovf.flag%0d", i), 32'(ovf_o), (i == 5) ? 1 : 0);
        end
        drive(1'b0, 5'd0, 0, 5'd0, 0);
        for (int i = 1; i <= 4; i++) begin
            check_port($sformatf("ovf.d%0d", i), 1'b1, 5'(20 + i), 32'h200 + 32'(i));
            tick();
        end
        check("ovf.empty", 32'(fifo_count), 0);
        check_port("ovf.nodrop", 1'b0, 5'd0, 0);
        check("ovf.held", 32'(ovf_o), 1);

        // Hazards against in-flight divider destinations.
        div_rd_addr_flags = 32'h0000_0200;
        set_id(5'd0, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0);
        check("haz.rs2", 32'(stall_o), 1);
        set_id(5'd0, 1'b0, 5'd9, 1'b0, 5'd0, 1'b0);
        check("haz.rs2unused", 32'(stall_o), 0);
        set_id(5'd0, 1'b0, 5'd8, 1'b1, 5'd0, 1'b0);
        check("haz.rs2other", 32'(stall_o), 0);
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
        check("haz.waw", 32'(stall_o), 1);
        set_id(5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        check("haz.rs1", 32'(stall_o), 1);
        div_rd_addr_flags = 32'h0000_0001;
        set_id(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1);
        check("haz.x0", 32'(stall_o), 0);
        div_rd_addr_flags = '0;
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);

        // Async reset mid-cycle with two buffered entries.
        for (int i = 1; i <= 2; i++) begin
            drive(1'b1, 5'd30, 32'hE0, 5'(10 + i), 32'h300 + 32'(i));
            tick();
        end
        check("ar.count2", 32'(fifo_count), 2);
        drive(1'b1, 5'd30, 32'hE1, 5'd0, 0);
        #1;
        rst = 1'b1;
        #1;
        check("ar.count", 32'(fifo_count), 0);
        check("ar.ovf", 32'(ovf_o), 0);
        check("ar.rf_we", 32'(rf_we), 0);
        check("ar.waddr", 32'(rf_waddr), 0);
        check("ar.stall", 32'(stall_o), 0);
        #1;
        rst = 1'b0;
        drive(1'b0, 5'd0, 0, 5'd0, 0);
        check_port("ar.post", 1'b0, 5'd0, 0);
        tick();
        check_port("ar.post2", 1'b0, 5'd0, 0);
        check("ar.count_post", 32'(fifo_count), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
